mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit: in-order uop acceptance, a circular store buffer with
// store-to-load forwarding, and a single-outstanding dcache port.
module mem_lsu #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int RES_W    = 128,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_op,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [1:0]                    in_size,
  input  logic                          in_sext,
  input  logic [DATA_W-1:0]             in_wdata,
  input  logic [RES_W-1:0]              in_pass,
  output logic                          wb_valid,
  output logic [RES_W-1:0]              wb_result,
  output logic                          dc_req,
  output logic                          dc_we,
  output logic [ADDR_W-1:0]             dc_addr,
  output logic [DATA_W-1:0]             dc_wdata,
  output logic [1:0]                    dc_size,
  input  logic                          dc_done,
  input  logic [DATA_W-1:0]             dc_rdata,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);

  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef enum logic [1:0] {P_IDLE = 2'd0, P_LOAD = 2'd1, P_STORE = 2'd2} port_e;

  // Number of valid bits for an access of 2**sz bytes, capped at the bus width.
  function automatic int access_bits(input logic [1:0] sz);
    int nb;
    nb = 8 << sz;
    if (nb > DATA_W) nb = DATA_W;
    return nb;
  endfunction

  // Keep only the bytes a store of this size actually writes.
  function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] keep;
    keep = (DATA_W'(1) << access_bits(sz)) - DATA_W'(1);
    return d & keep;
  endfunction

  // Truncate load data to its access size, then sign- or zero-extend.
  function automatic logic [RES_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                input logic [1:0] sz,
                                                input logic sx);
    logic [RES_W-1:0] dx, keep;
    logic             msb;
    dx   = RES_W'(d);
    keep = (RES_W'(1) << access_bits(sz)) - RES_W'(1);
    msb  = |(dx & (RES_W'(1) << (access_bits(sz) - 1)));
    return (dx & keep) | ((sx && msb) ? ~keep : '0);
  endfunction

  // Byte ranges [a, a+2**s) intersect; one extra bit avoids wrap at the top.
  function automatic logic overlap(input logic [ADDR_W-1:0] a0, input logic [1:0] s0,
                                   input logic [ADDR_W-1:0] a1, input logic [1:0] s1);
    logic [ADDR_W:0] lo0, hi0, lo1, hi1;
    lo0 = {1'b0, a0};
    hi0 = lo0 + ((ADDR_W+1)'(1) << s0);
    lo1 = {1'b0, a1};
    hi1 = lo1 + ((ADDR_W+1)'(1) << s1);
    return (lo0 < hi1) && (lo1 < hi0);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Physical slot of the i-th oldest store-buffer entry.
  function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] h, input int i);
    int t;
    t = int'(h) + i;
    if (t >= SB_DEPTH) t -= SB_DEPTH;
    return PTR_W'(t);
  endfunction

  port_e              port_q, port_d;
  logic               dc_req_q, dc_req_d, dc_we_q, dc_we_d;
  logic [ADDR_W-1:0]  dc_addr_q, dc_addr_d;
  logic [DATA_W-1:0]  dc_wdata_q, dc_wdata_d;
  logic [1:0]         dc_size_q, dc_size_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RES_W-1:0]   wb_result_q, wb_result_d;
  logic               ld_pend_q, ld_pend_d, ld_sext_q, ld_sext_d;
  logic [ADDR_W-1:0]  ld_addr_q, ld_addr_d;
  logic [1:0]         ld_size_q, ld_size_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  sb_addr_q [SB_DEPTH];
  logic [1:0]         sb_size_q [SB_DEPTH];
  logic [DATA_W-1:0]  sb_data_q [SB_DEPTH];

  logic               accept, enq, deq, sb_hit, fwd_ok;
  logic [ADDR_W-1:0]  q_addr;
  logic [1:0]         q_size;
  logic [DATA_W-1:0]  fwd_data;

  // Ready depends only on registered state; held low while reset is asserted.
  assign in_ready = reset_n && !ld_pend_q && (cnt_q < CNT_W'(SB_DEPTH));
  assign accept   = in_valid && in_ready;
  assign enq      = accept && (in_op == OP_STORE);
  assign deq      = (port_q == P_STORE) && dc_done;

  // Search the store buffer oldest-to-youngest for the load being accepted or waiting.
  always_comb begin
    q_addr   = ld_pend_q ? ld_addr_q : in_addr;
    q_size   = ld_pend_q ? ld_size_q : in_size;
    sb_hit   = 1'b0;
    fwd_ok   = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (i < int'(cnt_q) &&
          overlap(q_addr, q_size, sb_addr_q[age_idx(head_q, i)], sb_size_q[age_idx(head_q, i)])) begin
        sb_hit   = 1'b1;
        fwd_ok   = (sb_addr_q[age_idx(head_q, i)] == q_addr) &&
                   (sb_size_q[age_idx(head_q, i)] == q_size);
        fwd_data = sb_data_q[age_idx(head_q, i)];
      end
    end
  end

  // Next-state: retirement, pending load, store-buffer pointers and dcache port FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    port_d      = port_q;
    dc_req_d    = dc_req_q;
    dc_we_d     = dc_we_q;
    dc_addr_d   = dc_addr_q;
    dc_wdata_d  = dc_wdata_q;
    dc_size_d   = dc_size_q;
    wb_valid_d  = 1'b0;
    wb_result_d = wb_result_q;
    ld_pend_d   = ld_pend_q;
    ld_addr_d   = ld_addr_q;
    ld_size_d   = ld_size_q;
    ld_sext_d   = ld_sext_q;
    head_d      = deq ? ptr_inc(head_q) : head_q;
    tail_d      = enq ? ptr_inc(tail_q) : tail_q;
    cnt_d       = cnt_q + CNT_W'(enq) - CNT_W'(deq);

    if (accept) begin
      case (in_op)
        OP_STORE: begin
          wb_valid_d  = 1'b1;
          wb_result_d = '0;
        end
        OP_LOAD: begin
          if (sb_hit && fwd_ok) begin
            wb_valid_d  = 1'b1;
            wb_result_d = load_ext(fwd_data, in_size, in_sext);
          end else begin
            ld_pend_d = 1'b1;
            ld_addr_d = in_addr;
            ld_size_d = in_size;
            ld_sext_d = in_sext;
          end
        end
        default: begin
          wb_valid_d  = 1'b1;
          wb_result_d = in_pass;
        end
      endcase
    end

    case (port_q)
      P_IDLE: begin
        if ((ld_pend_q || (accept && in_op == OP_LOAD)) && !sb_hit) begin
          port_d     = P_LOAD;
          dc_req_d   = 1'b1;
          dc_we_d    = 1'b0;
          dc_addr_d  = q_addr;
          dc_size_d  = q_size;
          dc_wdata_d = '0;
        end else if (cnt_q != '0) begin
          port_d     = P_STORE;
          dc_req_d   = 1'b1;
          dc_we_d    = 1'b1;
          dc_addr_d  = sb_addr_q[head_q];
          dc_size_d  = sb_size_q[head_q];
          dc_wdata_d = sb_data_q[head_q];
        end
      end
      P_LOAD, P_STORE: begin
        if (dc_done) begin
          port_d     = P_IDLE;
          dc_req_d   = 1'b0;
          dc_we_d    = 1'b0;
          dc_addr_d  = '0;
          dc_wdata_d = '0;
          dc_size_d  = '0;
          if (port_q == P_LOAD) begin
            wb_valid_d  = 1'b1;
            wb_result_d = load_ext(dc_rdata, ld_size_q, ld_sext_q);
            ld_pend_d   = 1'b0;
          end
        end
      end
      default: port_d = P_IDLE;
    endcase
  end

  // Control and output registers; reset discards buffered stores and in-flight loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q      <= P_IDLE;
      dc_req_q    <= 1'b0;
      dc_we_q     <= 1'b0;
      dc_addr_q   <= '0;
      dc_wdata_q  <= '0;
      dc_size_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_size_q   <= '0;
      ld_sext_q   <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      port_q      <= port_d;
      dc_req_q    <= dc_req_d;
      dc_we_q     <= dc_we_d;
      dc_addr_q   <= dc_addr_d;
      dc_wdata_q  <= dc_wdata_d;
      dc_size_q   <= dc_size_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_size_q   <= ld_size_d;
      ld_sext_q   <= ld_sext_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end

  // Store-buffer payload written at the tail on enqueue.
  // NOTE: payload is not reset; cnt_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_q[tail_q] <= in_addr;
      sb_size_q[tail_q] <= in_size;
      sb_data_q[tail_q] <= mask_data(in_wdata, in_size);
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_result = wb_result_q;
  assign dc_req    = dc_req_q;
  assign dc_we     = dc_we_q;
  assign dc_addr   = dc_addr_q;
  assign dc_wdata  = dc_wdata_q;
  assign dc_size   = dc_size_q;
  assign sb_count  = cnt_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a vector table for single-cycle retirement and
// forwarding, plus hand-written sequences for dcache, full-buffer and reset cases.
module tb_mem_lsu;

  localparam logic [1:0] OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2, OP_RSV = 2'd3;

  logic         clk;
  logic         reset_n;
  logic         in_valid, in_ready, in_sext;
  logic [1:0]   in_op, in_size;
  logic [63:0]  in_addr, in_wdata;
  logic [127:0] in_pass;
  logic         wb_valid;
  logic [127:0] wb_result;
  logic         dc_req, dc_we, dc_done;
  logic [63:0]  dc_addr, dc_wdata, dc_rdata;
  logic [1:0]   dc_size;
  logic [2:0]   sb_count;

  mem_lsu #(.ADDR_W(64), .DATA_W(64), .RES_W(128), .SB_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_size(in_size), .in_sext(in_sext), .in_wdata(in_wdata), .in_pass(in_pass),
    .wb_valid(wb_valid), .wb_result(wb_result),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_size(dc_size), .dc_done(dc_done), .dc_rdata(dc_rdata), .sb_count(sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: dcache reads issued, and writeback pulses, while enabled.
  logic rd_mon = 1'b0, wb_mon = 1'b0;
  int   rd_cnt = 0, wb_cnt = 0;
  always @(negedge clk) begin
    if (rd_mon && dc_req && !dc_we) rd_cnt++;
    if (wb_mon && wb_valid) wb_cnt++;
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = OP_NONE; in_addr = '0; in_size = '0;
    in_sext = 1'b0; in_wdata = '0; in_pass = '0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] addr, input logic [1:0] sz,
                       input logic sx, input logic [63:0] wd, input logic [127:0] ps);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_size = sz;
    in_sext = sx; in_wdata = wd; in_pass = ps;
  endtask

  // Called at a negedge; polls for dc_req with a bounded budget.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!dc_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " dc_req"}, 128'(dc_req), 128'(1'b1));
  endtask

  task automatic pulse_done();
    dc_done = 1'b1;
    @(posedge clk);
    #1 dc_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain_one(input logic [63:0] addr, input logic [63:0] data);
    wait_req("drain");
    check("drain we",    128'(dc_we),    128'(1'b1));
    check("drain addr",  128'(dc_addr),  128'(addr));
    check("drain wdata", 128'(dc_wdata), 128'(data));
    pulse_done();
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [63:0]  addr;
    logic [1:0]   size;
    logic         sext;
    logic [63:0]  wdata;
    logic [127:0] pass;
    logic [127:0] exp_res;
    logic [2:0]   exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_NONE,  64'h0,   2'd0, 1'b0, 64'h0, 128'hAB, 128'hAB, 3'd0};
    vecs[1] = '{OP_RSV,   64'h0,   2'd0, 1'b0, 64'h0, 128'h5555, 128'h5555, 3'd0};
    vecs[2] = '{OP_STORE, 64'h100, 2'd3, 1'b0, 64'h1122334455667788, 128'h0, 128'h0, 3'd1};
    vecs[3] = '{OP_LOAD,  64'h100, 2'd3, 1'b0, 64'h0, 128'h0, 128'h1122334455667788, 3'd1};
    vecs[4] = '{OP_STORE, 64'h180, 2'd1, 1'b0, 64'hABCD8001, 128'h0, 128'h0, 3'd2};
    vecs[5] = '{OP_LOAD,  64'h180, 2'd1, 1'b1, 64'h0, 128'h0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF8001, 3'd2};
    vecs[6] = '{OP_LOAD,  64'h180, 2'd1, 1'b0, 64'h0, 128'h0, 128'h8001, 3'd2};
    vecs[7] = '{OP_STORE, 64'h100, 2'd3, 1'b0, 64'hA5A5A5A5_5A5A5A5A, 128'h0, 128'h0, 3'd3};
    vecs[8] = '{OP_LOAD,  64'h100, 2'd3, 1'b0, 64'h0, 128'h0, 128'hA5A5A5A5_5A5A5A5A, 3'd3};
    vecs[9] = '{OP_NONE,  64'h0,   2'd0, 1'b0, 64'h0, {128{1'b1}}, {128{1'b1}}, 3'd3};

    idle_inputs();
    dc_done = 1'b0; dc_rdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready",  128'(in_ready),  128'(1'b0));
    check("rst wb_valid",  128'(wb_valid),  128'(1'b0));
    check("rst wb_result", wb_result,       128'h0);
    check("rst dc_req",    128'(dc_req),    128'(1'b0));
    check("rst sb_count",  128'(sb_count),  128'(3'd0));
    reset_n = 1'b1;
    #1 check("in_ready after reset", 128'(in_ready), 128'(1'b1));
    @(negedge clk);

    // Op none: one-cycle pulse, result held afterwards, no dcache traffic.
    drive(OP_NONE, 64'h0, 2'd0, 1'b0, 64'h0, 128'hAB);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("none wb_valid",  128'(wb_valid), 128'(1'b1));
    check("none wb_result", wb_result,      128'hAB);
    check("none dc_req",    128'(dc_req),   128'(1'b0));
    @(negedge clk);
    check("none pulse end", 128'(wb_valid), 128'(1'b0));
    check("none held",      wb_result,      128'hAB);

    // Vector table: dc_done stays low so every store stays buffered.
    rd_mon = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].size, vecs[i].sext, vecs[i].wdata, vecs[i].pass);
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      check($sformatf("vec%0d wb_valid", i),  128'(wb_valid), 128'(1'b1));
      check($sformatf("vec%0d wb_result", i), wb_result,      vecs[i].exp_res);
      check($sformatf("vec%0d sb_count", i),  128'(sb_count), 128'(vecs[i].exp_cnt));
    end
    rd_mon = 1'b0;
    check("forwarding issued no dcache read", 128'(rd_cnt), 128'(0));
    check("head store held addr", 128'(dc_addr), 128'(64'h100));
    drain_one(64'h100, 64'h1122334455667788);
    drain_one(64'h180, 64'h8001);
    drain_one(64'h100, 64'hA5A5A5A5_5A5A5A5A);
    check("table drained", 128'(sb_count), 128'(3'd0));

    // Partial overlap: load waits for the store to drain, then reads dcache.
    drive(OP_STORE, 64'h100, 2'd3, 1'b0, 64'h1122334455667788, 128'h0);
    @(posedge clk);
    #1 drive(OP_LOAD, 64'h104, 2'd0, 1'b1, 64'h0, 128'h0);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("ovl in_ready",  128'(in_ready), 128'(1'b0));
    check("ovl store 1st", 128'(dc_we),    128'(1'b1));
    check("ovl store addr", 128'(dc_addr), 128'(64'h100));
    repeat (2) @(negedge clk);
    check("ovl still store", 128'(dc_we),  128'(1'b1));
    check("ovl no wb",     128'(wb_valid), 128'(1'b0));
    pulse_done();
    wait_req("ovl load");
    check("ovl load we",   128'(dc_we),   128'(1'b0));
    check("ovl load addr", 128'(dc_addr), 128'(64'h104));
    check("ovl load size", 128'(dc_size), 128'(2'd0));
    dc_rdata = 64'h80;
    pulse_done();
    check("ovl wb_valid",  128'(wb_valid), 128'(1'b1));
    check("ovl wb_result", wb_result,      {{120{1'b1}}, 8'h80});
    check("ovl ready",     128'(in_ready), 128'(1'b1));

    // Plain load with three wait cycles.
    drive(OP_LOAD, 64'h200, 2'd1, 1'b0, 64'h0, 128'h0);
    @(posedge clk);
    #1 idle_inputs();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check($sformatf("ld wait%0d dc_req", w), 128'(dc_req),  128'(1'b1));
      check($sformatf("ld wait%0d addr", w),   128'(dc_addr), 128'(64'h200));
      check($sformatf("ld wait%0d size", w),   128'(dc_size), 128'(2'd1));
      check($sformatf("ld wait%0d we", w),     128'(dc_we),   128'(1'b0));
      check($sformatf("ld wait%0d wb", w),     128'(wb_valid), 128'(1'b0));
    end
    dc_rdata = 64'hFFFF8001;
    pulse_done();
    check("ld wb_valid",  128'(wb_valid), 128'(1'b1));
    check("ld wb_result", wb_result,      128'h8001);

    // Fill the buffer, then exercise full/dequeue and same-cycle enq+deq.
    for (int i = 0; i < 4; i++) begin
      drive(OP_STORE, 64'(32'h300 + 8 * i), 2'd3, 1'b0, 64'(32'hD000 + i), 128'h0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(negedge clk);
    check("full count",    128'(sb_count), 128'(3'd4));
    check("full in_ready", 128'(in_ready), 128'(1'b0));
    check("full head",     128'(dc_addr),  128'(64'h300));
    drive(OP_STORE, 64'h320, 2'd3, 1'b0, 64'hD004, 128'h0);
    pulse_done();
    check("full deq count",   128'(sb_count), 128'(3'd3));
    check("full no accept",   128'(wb_valid), 128'(1'b0));
    check("full ready again", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("refill count", 128'(sb_count), 128'(3'd4));
    check("refill wb",    128'(wb_valid), 128'(1'b1));
    check("second head",  128'(dc_addr),  128'(64'h308));
    pulse_done();
    wait_req("third head");
    check("third head addr", 128'(dc_addr), 128'(64'h310));
    drive(OP_STORE, 64'h328, 2'd3, 1'b0, 64'hD005, 128'h0);
    dc_done = 1'b1;
    @(posedge clk);
    #1 dc_done = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("enq+deq count", 128'(sb_count), 128'(3'd3));
    check("enq+deq wb",    128'(wb_valid), 128'(1'b1));
    drain_one(64'h318, 64'hD003);
    drain_one(64'h320, 64'hD004);
    drain_one(64'h328, 64'hD005);
    check("wrap drained", 128'(sb_count), 128'(3'd0));

    // Reset with two buffered stores and a pending load.
    drive(OP_STORE, 64'h400, 2'd3, 1'b0, 64'h44, 128'h0);
    @(posedge clk);
    #1 drive(OP_STORE, 64'h408, 2'd3, 1'b0, 64'h48, 128'h0);
    @(posedge clk);
    #1 drive(OP_LOAD, 64'h500, 2'd3, 1'b0, 64'h0, 128'h0);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("pre-rst count", 128'(sb_count), 128'(3'd2));
    check("pre-rst ready", 128'(in_ready), 128'(1'b0));
    #2 reset_n = 1'b0;
    #1;
    check("mid-rst in_ready", 128'(in_ready), 128'(1'b0));
    check("mid-rst wb_valid", 128'(wb_valid), 128'(1'b0));
    check("mid-rst wb_result", wb_result,     128'h0);
    check("mid-rst dc_req",   128'(dc_req),   128'(1'b0));
    check("mid-rst dc_we",    128'(dc_we),    128'(1'b0));
    check("mid-rst dc_addr",  128'(dc_addr),  128'(64'h0));
    check("mid-rst dc_wdata", 128'(dc_wdata), 128'(64'h0));
    check("mid-rst dc_size",  128'(dc_size),  128'(2'd0));
    check("mid-rst sb_count", 128'(sb_count), 128'(3'd0));
    wb_mon  = 1'b1;
    dc_done = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("post-rst in_ready", 128'(in_ready), 128'(1'b1));
    repeat (4) @(negedge clk);
    check("late done dc_req",   128'(dc_req),   128'(1'b0));
    check("late done sb_count", 128'(sb_count), 128'(3'd0));
    dc_done = 1'b0;
    wb_mon  = 1'b0;
    check("no wb after reset", 128'(wb_cnt), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
